// File: rtl/stream_mux_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_mux_n_if : handshake bundle between producers, mux and consumer    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface stream_mux_n_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_mux_n : N-channel valid/ready mux with one-entry registered output |
// | Round-robin select compiled in with STREAM_MUX_RR_EN.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module stream_mux_n #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  stream_mux_n_if.slave  mux_io
);
  localparam int SEL_W = $clog2(CHANNELS);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  data_q;
  logic [SEL_W-1:0]  chan_q;
  logic [SEL_W-1:0]  ptr_q;

  logic              load_en;
  logic              rr_mode;
  logic              exp_vld;
  logic [SEL_W-1:0]  exp_idx;
  logic              rr_vld;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  rr_pos;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  gnt_data;
  logic              xfer;
  logic [CHANNELS-1:0] ready;

  assign load_en = (state_q == ST_EMPTY) | mux_io.out_ready;

`ifdef STREAM_MUX_RR_EN
  assign rr_mode = mux_io.mode;
`else
  // Without the arbiter the mode input is accepted but never selects it.
  assign rr_mode = mux_io.mode & 1'b0;
`endif

  // Out-of-range select values never match a channel, so they never grant.
  always_comb begin
    exp_vld = 1'b0;
    exp_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((mux_io.sel == SEL_W'(i)) && mux_io.in_valid[i]) begin
        exp_vld = 1'b1;
        exp_idx = SEL_W'(i);
      end
    end
  end

  // Scan from ptr+CHANNELS down to ptr+1 so the nearest valid channel wins.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    rr_pos = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      rr_pos = SEL_W'((int'(ptr_q) + k) % CHANNELS);
      if (mux_io.in_valid[rr_pos]) begin
        rr_vld = 1'b1;
        rr_idx = rr_pos;
      end
    end
  end

  assign gnt_vld = rr_mode ? rr_vld : exp_vld;
  assign gnt_idx = rr_mode ? rr_idx : exp_idx;
  assign xfer    = rst_n & load_en & gnt_vld;

  always_comb begin
    gnt_data = '0;
    ready    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = mux_io.in_data[i*WIDTH +: WIDTH];
        ready[i] = xfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      state_q <= ST_FULL;
      data_q  <= gnt_data;
      chan_q  <= gnt_idx;
      ptr_q   <= gnt_idx;
    end else if (mux_io.out_ready) begin
      state_q <= ST_EMPTY;
    end
  end

  assign mux_io.in_ready  = ready;
  assign mux_io.out_data  = data_q;
  assign mux_io.out_chan  = chan_q;
  assign mux_io.out_valid = (state_q == ST_FULL);

endmodule
`default_nettype wire
